// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and helper functions for the asymmetric packing RAM.
// Used by ram_asym_core and ram_asym_pack.
package ram_pkg;

  // Widest line the lane-mask helper can describe; callers cast the result down to their line width.
  localparam int MAX_LINE_W = 4096;

  // Number of lane-select bits for a given ratio (zero when a line holds a single lane).
  function automatic int lane_bits(input int ratio);
    return (ratio > 32'sd1) ? $clog2(ratio) : 32'sd0;
  endfunction

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v >= 32'sd1) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  // Parameter legality: lanes per line must be a power of two and the read latency at least one.
  function automatic bit params_legal(input int ratio, input int latency);
    return is_pow2(ratio) && (latency >= 32'sd1);
  endfunction

  // Bit mask covering one lane of a line; an out-of-range lane yields an empty mask.
  function automatic logic [MAX_LINE_W-1:0] lane_mask(input int lane, input int width_w, input int ratio);
    logic [MAX_LINE_W-1:0] m;
    m = {MAX_LINE_W{1'b0}};
    if ((lane >= 32'sd0) && (lane < ratio)) begin
      for (int b = 32'sd0; b < width_w; b++) begin
        m[b] = 1'b1;
      end
      m = m << (lane * width_w);
    end else begin
      m = {MAX_LINE_W{1'b0}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_asym_core.sv
// ram_asym_core: bare line array with per-lane write enables and a single read register.
// Deliberately free of reset so synthesis can map it onto block RAM with lane write enables.
module ram_asym_core import ram_pkg::*; #(
  parameter int WIDTH_W      = 8,
  parameter int RATIO        = 8,
  parameter int DEPTH_R      = 256,
  parameter int ADDR_R_WIDTH = 8,
  localparam int WIDTH_R     = WIDTH_W * RATIO,
  localparam int LANE_W      = (lane_bits(RATIO) > 0) ? lane_bits(RATIO) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [ADDR_R_WIDTH-1:0] i_wline,
  input  logic [LANE_W-1:0]       i_wlane,
  input  logic [WIDTH_W-1:0]      i_din,
  input  logic                    i_re,
  input  logic [ADDR_R_WIDTH-1:0] i_raddr,
  output logic [WIDTH_R-1:0]      o_q
);

  logic [WIDTH_R-1:0] r_mem [DEPTH_R];
  logic [WIDTH_R-1:0] r_q;

  // Lane write: only the addressed lane of the addressed line is updated
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < RATIO; l++) begin
        if (LANE_W'(l) == i_wlane) begin
          r_mem[i_wline][l*WIDTH_W +: WIDTH_W] <= i_din;
        end
      end
    end
  end

  // Read register: captures the whole line, holding its value when no read is issued
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ram_asym_pack.sv
// ram_asym_pack: narrow-write / wide-read packing RAM with a LATENCY-deep read pipeline.
// Optional feature macro RAM_ASYM_FWD_EN: same-cycle write/read of one line returns the
// freshly written lane (write-first); without it such a read returns pre-write contents.
module ram_asym_pack import ram_pkg::*; #(
  parameter int WIDTH_W       = 8,
  parameter int RATIO         = 8,
  parameter int DEPTH_R       = 256,
  parameter int LATENCY       = 2,
  localparam int WIDTH_R      = WIDTH_W * RATIO,
  localparam int ADDR_R_WIDTH = $clog2(DEPTH_R),
  localparam int ADDR_W_WIDTH = ADDR_R_WIDTH + lane_bits(RATIO)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_we,
  input  logic [ADDR_W_WIDTH-1:0] i_waddr,
  input  logic [WIDTH_W-1:0]      i_din,
  input  logic                    i_re,
  input  logic [ADDR_R_WIDTH-1:0] i_raddr,
  output logic [WIDTH_R-1:0]      o_dout,
  output logic                    o_dout_valid
);

  localparam int LANE_BITS = lane_bits(RATIO);
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam logic [ADDR_R_WIDTH:0] DEPTH_LIM = (ADDR_R_WIDTH+1)'(DEPTH_R);

  if (!params_legal(RATIO, LATENCY)) begin : g_param_check
    $error("ram_asym_pack: RATIO must be a power of two and LATENCY must be at least 1");
  end

  logic [ADDR_R_WIDTH-1:0] w_wline;
  logic [LANE_W-1:0]       w_wlane;
  logic                    w_win_range;
  logic                    w_rin_range;
  logic                    w_wacc;
  logic                    w_racc;
  logic [WIDTH_R-1:0]      w_core_q;
  logic [WIDTH_R-1:0]      w_s1_line;
  logic [WIDTH_R-1:0]      w_s1_data;
  logic                    r_v1;
  logic                    r_oor1;

  // Split the lane address into line and lane; a single-lane line has no lane field at all
  if (LANE_BITS > 0) begin : g_lanes
    assign w_wline = i_waddr[ADDR_W_WIDTH-1:LANE_BITS];
    assign w_wlane = i_waddr[LANE_BITS-1:0];
  end else begin : g_no_lanes
    assign w_wline = i_waddr;
    assign w_wlane = {LANE_W{1'b0}};
  end

  // Range checks only exist when the line count leaves unused address codes
  if ((1 << ADDR_R_WIDTH) == DEPTH_R) begin : g_full_depth
    assign w_win_range = 1'b1;
    assign w_rin_range = 1'b1;
  end else begin : g_partial_depth
    assign w_win_range = ({1'b0, w_wline} < DEPTH_LIM);
    assign w_rin_range = ({1'b0, i_raddr} < DEPTH_LIM);
  end

  assign w_wacc = i_en & i_we & ~i_rst & w_win_range;
  assign w_racc = i_en & i_re & ~i_rst & w_rin_range;

  ram_asym_core #(
    .WIDTH_W      (WIDTH_W),
    .RATIO        (RATIO),
    .DEPTH_R      (DEPTH_R),
    .ADDR_R_WIDTH (ADDR_R_WIDTH)
  ) u_core (
    .i_clk   (i_clk),
    .i_we    (w_wacc),
    .i_wline (w_wline),
    .i_wlane (w_wlane),
    .i_din   (i_din),
    .i_re    (w_racc),
    .i_raddr (i_raddr),
    .o_q     (w_core_q)
  );

  // Stage-1 tags: valid bit and out-of-range marker travel with the core read register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1   <= 1'b0;
      r_oor1 <= 1'b0;
    end else if (i_en) begin
      r_v1   <= i_re;
      r_oor1 <= ~w_rin_range;
    end
  end

`ifdef RAM_ASYM_FWD_EN
  logic               r_fwd1;
  logic [LANE_W-1:0]  r_fwd_lane1;
  logic [WIDTH_W-1:0] r_fwd_din1;
  logic [WIDTH_R-1:0] w_fwd_mask;

  // Remember a same-cycle write/read collision so the written lane can be merged into the line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd1      <= 1'b0;
      r_fwd_lane1 <= {LANE_W{1'b0}};
      r_fwd_din1  <= {WIDTH_W{1'b0}};
    end else if (i_en) begin
      r_fwd1      <= w_wacc & w_racc & (w_wline == i_raddr);
      r_fwd_lane1 <= w_wlane;
      r_fwd_din1  <= i_din;
    end
  end

  assign w_fwd_mask = WIDTH_R'(lane_mask(int'(r_fwd_lane1), WIDTH_W, RATIO));
  assign w_s1_line  = r_fwd1 ? ((w_core_q & ~w_fwd_mask) | ({RATIO{r_fwd_din1}} & w_fwd_mask))
                             : w_core_q;
`else
  assign w_s1_line = w_core_q;
`endif

  // Stage-1 result: empty slots and out-of-range reads present an all-zero line
  always_comb begin
    w_s1_data = {WIDTH_R{1'b0}};
    if (r_v1 && !r_oor1) begin
      w_s1_data = w_s1_line;
    end else begin
      w_s1_data = {WIDTH_R{1'b0}};
    end
  end

  if (LATENCY > 1) begin : g_pipe
    logic [WIDTH_R-1:0] r_pd [LATENCY-1];
    logic [LATENCY-2:0] r_pv;

    // Remaining read stages: cleared by reset, frozen while en is low
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int k = 0; k < LATENCY-1; k++) begin
          r_pd[k] <= {WIDTH_R{1'b0}};
          r_pv[k] <= 1'b0;
        end
      end else if (i_en) begin
        r_pd[0] <= w_s1_data;
        r_pv[0] <= r_v1;
        for (int k = 1; k < LATENCY-1; k++) begin
          r_pd[k] <= r_pd[k-1];
          r_pv[k] <= r_pv[k-1];
        end
      end
    end

    assign o_dout       = r_pd[LATENCY-2];
    assign o_dout_valid = r_pv[LATENCY-2];
  end else begin : g_no_pipe
    assign o_dout       = w_s1_data;
    assign o_dout_valid = r_v1;
  end

endmodule

// File: tb/tb_ram_asym_pack.sv
// Self-checking bench for ram_asym_pack: directed scenarios with literal expectations plus a
// randomized phase, all checked against a line-array / pending-read-queue model.
module tb_ram_asym_pack;

  localparam int WIDTH_W = 8;
  localparam int RATIO   = 8;
  localparam int DEPTH_R = 16;
  localparam int LATENCY = 2;

`ifdef RAM_ASYM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, we, re;
  logic [6:0]  waddr;
  logic [7:0]  din;
  logic [3:0]  raddr;
  logic [63:0] dout;
  logic        dout_valid;

  always #5 clk = ~clk;

  ram_asym_pack #(
    .WIDTH_W (WIDTH_W),
    .RATIO   (RATIO),
    .DEPTH_R (DEPTH_R),
    .LATENCY (LATENCY)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_we         (we),
    .i_waddr      (waddr),
    .i_din        (din),
    .i_re         (re),
    .i_raddr      (raddr),
    .o_dout       (dout),
    .o_dout_valid (dout_valid)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Behavioural model: line contents plus reads waiting for LATENCY enabled cycles
  typedef struct { logic [63:0] data; int age; } pend_t;
  logic [63:0] mm [DEPTH_R];
  pend_t       pq [$];
  logic        exp_v = 1'b0;
  logic [63:0] exp_d = 64'h0;
  bit          exp_known = 1'b0;
  logic [63:0] rv;
  pend_t       pe;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, got, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
      exp_v = 1'b0;
      exp_d = 64'h0;
      exp_known = 1'b1;
    end else if (en) begin
      for (int i = 0; i < pq.size(); i++) pq[i].age = pq[i].age + 1;
      if (re) begin
        rv = mm[raddr];
        if (FWD && we && (waddr[6:3] == raddr)) rv[waddr[2:0]*8 +: 8] = din;
        pe.data = rv;
        pe.age  = 1;
        pq.push_back(pe);
      end
      if (we) mm[waddr[6:3]][waddr[2:0]*8 +: 8] = din;
      if ((pq.size() > 0) && (pq[0].age == LATENCY)) begin
        exp_v = 1'b1;
        exp_d = pq[0].data;
        exp_known = 1'b1;
        void'(pq.pop_front());
      end else begin
        exp_v = 1'b0;
        exp_known = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", {63'h0, dout_valid}, {63'h0, exp_v});
      if (exp_v || exp_known) chk("dout", dout, exp_d);
    end
  end

  task automatic step(input logic e, input logic w, input logic [6:0] wa, input logic [7:0] d,
                      input logic r, input logic [3:0] ra, input logic rs);
    en = e; we = w; waddr = wa; din = d; re = r; raddr = ra; rst = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 7'h0, 8'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] ra);
    step(1'b1, 1'b0, 7'h0, 8'h0, 1'b1, ra, 1'b0);
  endtask

  int first_n, last_n, vcnt;
  logic [63:0] s3_exp;

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; re = 1'b0; waddr = 7'h0; din = 8'h0; raddr = 4'h0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_valid", {63'h0, dout_valid}, 64'h0);
    chk("rst_dout", dout, 64'h0);

    // Fill every lane of every line
    for (int l = 0; l < DEPTH_R; l++)
      for (int k = 0; k < RATIO; k++)
        step(1'b1, 1'b1, 7'(l*8 + k), 8'($urandom), 1'b0, 4'h0, 1'b0);

    // Lane packing
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 7'(i), 8'(17 * (i + 1)), 1'b0, 4'h0, 1'b0);
    rd(4'd0);
    chk("s1_valid_early", {63'h0, dout_valid}, 64'h0);
    idle();
    chk("s1_valid", {63'h0, dout_valid}, 64'h1);
    chk("s1_dout", dout, 64'h8877665544332211);
    chk("s1_model", exp_d, 64'h8877665544332211);
    idle();
    chk("s1_valid_once", {63'h0, dout_valid}, 64'h0);

    // Lane preservation
    step(1'b1, 1'b1, 7'd3, 8'hAA, 1'b0, 4'h0, 1'b0);
    rd(4'd0);
    idle();
    chk("s2_dout", dout, 64'h88776655AA332211);
    chk("s2_model", exp_d, 64'h88776655AA332211);
    idle();

    // Same-cycle write and read of one line
    s3_exp = FWD ? 64'h88776655AA3322FF : 64'h88776655AA332211;
    step(1'b1, 1'b1, 7'd0, 8'hFF, 1'b1, 4'd0, 1'b0);
    idle();
    chk("s3_dout", dout, s3_exp);
    chk("s3_model", exp_d, s3_exp);
    idle();

    // Stall before the result emerges: valid needs two enabled edges
    rd(4'd1);
    chk("s4a_v0", {63'h0, dout_valid}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 7'h0, 8'h0, 1'b0, 4'h0, 1'b0);
      chk("s4a_stall_v", {63'h0, dout_valid}, 64'h0);
    end
    idle();
    chk("s4a_valid", {63'h0, dout_valid}, 64'h1);
    chk("s4a_dout", dout, mm[1]);
    idle();
    chk("s4a_valid_once", {63'h0, dout_valid}, 64'h0);

    // Stall while a result is presented: outputs hold
    rd(4'd2);
    idle();
    chk("s4b_valid", {63'h0, dout_valid}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 7'd16, 8'h5A, 1'b1, 4'd2, 1'b0);
      chk("s4b_hold_v", {63'h0, dout_valid}, 64'h1);
      chk("s4b_hold_d", dout, mm[2]);
    end
    idle();
    chk("s4b_after", {63'h0, dout_valid}, 64'h0);

    // Reset in the middle of a burst
    rd(4'd3);
    step(1'b1, 1'b1, 7'd24, 8'h77, 1'b1, 4'd4, 1'b1);
    chk("s5_rst_v", {63'h0, dout_valid}, 64'h0);
    chk("s5_rst_d", dout, 64'h0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("s5_post_v", {63'h0, dout_valid}, 64'h0);
    end

    // Streaming: one result per cycle, in order
    first_n = -1; last_n = -1; vcnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (n < 16) rd(4'(n));
      else idle();
      if (dout_valid) begin
        vcnt++;
        if (first_n < 0) first_n = n + 1;
        last_n = n + 1;
      end
    end
    chk("s6_count", 64'(vcnt), 64'd16);
    chk("s6_first", 64'(first_n), 64'd2);
    chk("s6_last", 64'(last_n), 64'd17);

    // Randomized traffic with occasional stalls and resets
    for (int n = 0; n < 3000; n++) begin
      step(1'(($urandom % 4) != 0), 1'($urandom), 7'($urandom), 8'($urandom),
           1'($urandom), 4'($urandom), 1'(($urandom % 100) == 0));
    end
    repeat (4) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_asym_pack.md
# ram_asym_pack

Simple-dual-port packing RAM: a narrow write port stores one lane of WIDTH_W bits per cycle, and a wide read port returns a whole line of RATIO lanes. It is the parametrised successor of the fixed 8:1 read-wider RAM, with these additions:
- arbitrary power-of-two RATIO;
- true per-lane writes, leaving other lanes intact;
- a configurable read latency with a valid flag;
- optional write-to-read collision forwarding.

It sits between the input DMA width converter and the edge/weight buffers. Those buffers consume full K_BITS-wide lines.

## Interface
Parameters:
- WIDTH_W, 8: write lane width in bits.
- RATIO, 8: lanes per line; must be a power of two, ≥1.
- DEPTH_R, 256: number of lines.
- LATENCY, 2: read latency in cycles; must be ≥1.
- WIDTH_R, WIDTH_W*RATIO: read width; derived, not overridable.
- ADDR_R_WIDTH, $clog2(DEPTH_R): derived.
- ADDR_W_WIDTH, ADDR_R_WIDTH+$clog2(RATIO): derived.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global clock enable; gates writes, reads and pipeline advance.
- we  in  1  write strobe.
- waddr  in  ADDR_W_WIDTH  lane address; upper bits select the line, low $clog2(RATIO) bits select the lane.
- din  in  WIDTH_W  write data.
- re  in  1  read strobe.
- raddr  in  ADDR_R_WIDTH  line address.
- dout  out  WIDTH_R  read line; lane 0 is in bits [WIDTH_W-1:0].
- dout_valid  out  1  dout holds the result of an accepted read.

## Operation
- Write accepted when en & we & !rst:
  - line = waddr >> log2(RATIO); lane = waddr[log2(RATIO)-1:0].
  - Sets mem[line][lane*WIDTH_W +: WIDTH_W] = din.
  - All other lanes of that line are unchanged. This is a bit-masked write; nothing is zeroed.
- Read accepted when en & re & !rst: samples mem[raddr] into stage 1 of a LATENCY-deep pipeline. The valid bit travels alongside the data.
- RATIO=1: degenerates to a plain WIDTH_W simple-dual-port RAM. Lane select is zero-width and must not be elaborated.
- Memory contents are not reset and are X until written.
- Out-of-range addresses (line ≥ DEPTH_R when DEPTH_R is not a power of two):
  - writes are dropped;
  - reads return 0 with dout_valid still asserted.

## Timing
- Read issued in cycle t (en high) → dout/dout_valid at t+LATENCY, provided en is high in every intervening cycle.
- en low freezes the entire pipeline, including dout and dout_valid. In-flight reads resume when en returns.
- dout_valid is high for exactly one cycle per accepted read if en stays high; back-to-back reads produce one result every cycle.
- Write visibility: a write in cycle t is visible to any read issued in t+1 or later.
- Same-cycle write and read to the same line: see Configuration.
- Reset:
  - dout = 0, dout_valid = 0, and every pipeline stage is cleared on the cycle after rst is sampled high.
  - In-flight reads are discarded.
  - A write or read presented while rst is high is ignored.
  - Reset asserted mid-burst gives no partial outputs afterwards.
- Registered outputs only; there are no combinational paths from inputs to outputs.

## Configuration
- RAM_ASYM_FWD_EN defined: a same-cycle write to line L and read of line L returns the line with din already merged into the written lane. This is write-first behaviour for that lane.
- RAM_ASYM_FWD_EN undefined: the read returns the line's pre-write contents (read-first). The forwarding mux and compare logic are not elaborated.

## Structure
- Shared package ram_pkg holds:
  - function lane_mask(lane, WIDTH_W, RATIO), which returns a WIDTH_R-bit mask;
  - the derived log2 constant;
  - a parameter-legality check function.
- Elaboration $error when RATIO is not a power of two or LATENCY < 1.
- One sub-module, ram_asym_core: the bare masked-write array plus first read register, with no reset. This lets synthesis infer BRAM with byte/lane write enables.
- The top level holds:
  - the LATENCY-1 stage valid/data pipeline, with reset;
  - the forwarding logic;
  - the range checks.

## Test plan
Bench configuration: WIDTH_W=8, RATIO=8, DEPTH_R=16, LATENCY=2.
1. Lane packing: write 0x11..0x88 to waddr 0..7, then read raddr 0 → 0x8877665544332211 at t+2, with dout_valid high for 1 cycle.
2. Lane preservation: after scenario 1, write 0xAA to waddr 3, then read line 0 → 0x88776655AA332211.
3. Collision: in one cycle, write 0xFF to waddr 0 and read raddr 0 (after scenario 2):
   - with RAM_ASYM_FWD_EN → 0x88776655AA3322FF;
   - without → 0x88776655AA332211.
4. Stall: issue a read, then drop en for 3 cycles after 1 cycle → dout_valid rises exactly 2 en-high cycles after issue; dout remains stable during the stall.
5. Reset mid-operation: issue reads at t and t+1, assert rst at t+1 → dout=0 and dout_valid=0 from t+2, and no valid output afterwards.
6. Streaming: reads on lines 0..15 in 16 consecutive cycles → 16 consecutive valid lines in order, with line 15 appearing at cycle 17.
